// File: rtl/id_ctrl_flow.sv
// ID-stage control-flow unit: IF/ID register, branch/jump decode, operand forwarding and hazard stall.
// Optional FLUSH_DELAY_SLOT_EN squashes the delay slot on a taken transfer.
module id_ctrl_flow #(
  parameter int unsigned STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [31:0]            if_instr,
  input  logic [31:0]            if_pc,
  input  logic [31:0]            rf_rs_data,
  input  logic [31:0]            rf_rt_data,
  input  logic                   ex_wr_en,
  input  logic                   ex_is_load,
  input  logic [4:0]             ex_wr_reg,
  input  logic                   mem_wr_en,
  input  logic                   mem_is_load,
  input  logic [4:0]             mem_wr_reg,
  input  logic [31:0]            mem_result,
  output logic [31:0]            id_instr,
  output logic [31:0]            id_pc,
  output logic [4:0]             rs_addr,
  output logic [4:0]             rt_addr,
  output logic [1:0]             branch_sel,
  output logic [1:0]             j_sel,
  output logic [15:0]            i_imme,
  output logic [25:0]            j_imme,
  output logic [31:0]            rs_data,
  output logic [31:0]            rt_data,
  output logic                   stall,
  output logic                   id_bubble,
  output logic                   taken,
  output logic [STALL_CNT_W-1:0] stall_cnt
);

  typedef enum logic [1:0] {
    BR_NOP = 2'b00,
    BR_BEQ = 2'b01,
    BR_BNE = 2'b10
  } br_sel_e;

  typedef enum logic [1:0] {
    J_NOP = 2'b00,
    J_J   = 2'b01,
    J_JR  = 2'b10,
    J_JAL = 2'b11
  } j_sel_e;

  logic [31:0]            r_id_instr;
  logic [31:0]            r_id_pc;
  logic [STALL_CNT_W-1:0] r_stall_cnt;

  br_sel_e     w_br_dec;
  j_sel_e      w_j_dec;
  logic [4:0]  w_rs;
  logic [4:0]  w_rt;
  logic        w_use_rs;
  logic        w_use_rt;
  logic        w_haz_rs;
  logic        w_haz_rt;
  logic        w_stall;
  logic        w_taken_raw;
  logic        w_taken;
  logic [31:0] w_rs_data;
  logic [31:0] w_rt_data;
  logic        w_unused_ex_is_load;

  assign w_rs = r_id_instr[25:21];
  assign w_rt = r_id_instr[20:16];

  always_comb begin
    w_br_dec = BR_NOP;
    w_j_dec  = J_NOP;
    unique case (r_id_instr[31:26])
      6'b000100: w_br_dec = BR_BEQ;
      6'b000101: w_br_dec = BR_BNE;
      6'b000010: w_j_dec  = J_J;
      6'b000011: w_j_dec  = J_JAL;
      6'b000000: if (r_id_instr[5:0] == 6'b001000) w_j_dec = J_JR;
      default: ;
    endcase
  end

  always_comb begin
    w_rs_data = rf_rs_data;
    w_rt_data = rf_rt_data;
    if (mem_wr_en && !mem_is_load && (mem_wr_reg == w_rs) && (w_rs != 5'd0))
      w_rs_data = mem_result;
    if (mem_wr_en && !mem_is_load && (mem_wr_reg == w_rt) && (w_rt != 5'd0))
      w_rt_data = mem_result;
  end

  // Any EX writer stalls; a load simply stalls one more cycle once it reaches MEM.
  assign w_unused_ex_is_load = ex_is_load;

  assign w_use_rs = (w_br_dec != BR_NOP) || (w_j_dec == J_JR);
  assign w_use_rt = (w_br_dec != BR_NOP);

  assign w_haz_rs = (w_rs != 5'd0) &&
                    ((ex_wr_en && (ex_wr_reg == w_rs)) ||
                     (mem_wr_en && mem_is_load && (mem_wr_reg == w_rs)));
  assign w_haz_rt = (w_rt != 5'd0) &&
                    ((ex_wr_en && (ex_wr_reg == w_rt)) ||
                     (mem_wr_en && mem_is_load && (mem_wr_reg == w_rt)));

  assign w_stall = (w_use_rs && w_haz_rs) || (w_use_rt && w_haz_rt);

  assign w_taken_raw = ((w_br_dec == BR_BEQ) && (w_rs_data == w_rt_data)) ||
                       ((w_br_dec == BR_BNE) && (w_rs_data != w_rt_data)) ||
                       (w_j_dec != J_NOP);
  assign w_taken     = w_taken_raw && !w_stall;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_id_instr <= '0;
      r_id_pc    <= '0;
    end else if (!w_stall) begin
`ifdef FLUSH_DELAY_SLOT_EN
      r_id_instr <= w_taken ? '0 : if_instr;
`else
      r_id_instr <= if_instr;
`endif
      r_id_pc    <= if_pc;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall_cnt <= '0;
    end else if (w_stall && (r_stall_cnt != '1)) begin
      r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

  assign id_instr   = r_id_instr;
  assign id_pc      = r_id_pc;
  assign rs_addr    = w_rs;
  assign rt_addr    = w_rt;
  assign branch_sel = w_stall ? BR_NOP : w_br_dec;
  assign j_sel      = w_stall ? J_NOP  : w_j_dec;
  assign i_imme     = r_id_instr[15:0];
  assign j_imme     = r_id_instr[25:0];
  assign rs_data    = w_rs_data;
  assign rt_data    = w_rt_data;
  assign stall      = w_stall;
  assign id_bubble  = w_stall;
  assign taken      = w_taken;
  assign stall_cnt  = r_stall_cnt;

endmodule

// File: tb/tb_id_ctrl_flow.sv
// Directed bench for id_ctrl_flow; expectations queued in a scoreboard and popped at each sample point.
module tb_id_ctrl_flow;

  localparam logic [31:0] BEQ12 = 32'h1022_0010; // beq $1,$2,0x10
  localparam logic [31:0] BEQ30 = 32'h1060_0008; // beq $3,$0,0x8
  localparam logic [31:0] JMP   = 32'h0800_0040; // j 0x40
  localparam logic [31:0] DS    = 32'h2108_0001; // addi (delay slot)
  localparam logic [31:0] JR4   = 32'h0080_0008; // jr $4
  localparam logic [31:0] BNE05 = 32'h1405_0004; // bne $0,$5,0x4
  localparam logic [31:0] FILL  = 32'h2000_0000; // addi, non-control

  logic        clk, rst;
  logic [31:0] if_instr, if_pc, rf_rs_data, rf_rt_data, mem_result;
  logic        ex_wr_en, ex_is_load, mem_wr_en, mem_is_load;
  logic [4:0]  ex_wr_reg, mem_wr_reg;
  logic [31:0] id_instr, id_pc, rs_data, rt_data;
  logic [4:0]  rs_addr, rt_addr;
  logic [1:0]  branch_sel, j_sel;
  logic [15:0] i_imme;
  logic [25:0] j_imme;
  logic        stall, id_bubble, taken;
  logic [15:0] stall_cnt;

  id_ctrl_flow #(.STALL_CNT_W(16)) dut (
    .clk(clk), .rst(rst), .if_instr(if_instr), .if_pc(if_pc),
    .rf_rs_data(rf_rs_data), .rf_rt_data(rf_rt_data),
    .ex_wr_en(ex_wr_en), .ex_is_load(ex_is_load), .ex_wr_reg(ex_wr_reg),
    .mem_wr_en(mem_wr_en), .mem_is_load(mem_is_load), .mem_wr_reg(mem_wr_reg),
    .mem_result(mem_result), .id_instr(id_instr), .id_pc(id_pc),
    .rs_addr(rs_addr), .rt_addr(rt_addr), .branch_sel(branch_sel), .j_sel(j_sel),
    .i_imme(i_imme), .j_imme(j_imme), .rs_data(rs_data), .rt_data(rt_data),
    .stall(stall), .id_bubble(id_bubble), .taken(taken), .stall_cnt(stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];
  int   n_pass  = 0;
  int   n_total = 0;

  task automatic push(input string tag, input logic [31:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    sb.push_back(e);
  endtask

  task automatic chk(input logic [31:0] obs);
    exp_t e;
    n_total++;
    if (sb.size() == 0) begin
      $error("FAIL scoreboard_empty observed=%h expected=<none>", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.val) n_pass++;
      else $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.val);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    if_instr = '0; if_pc = '0; rf_rs_data = '0; rf_rt_data = '0; mem_result = '0;
    ex_wr_en = 1'b0; ex_is_load = 1'b0; ex_wr_reg = '0;
    mem_wr_en = 1'b0; mem_is_load = 1'b0; mem_wr_reg = '0;

    // Reset state
    #2;
    push("rst_id_instr", 32'h0); push("rst_id_pc", 32'h0); push("rst_stall_cnt", 32'h0);
    push("rst_branch_sel", 32'h0); push("rst_j_sel", 32'h0); push("rst_stall", 32'h0);
    push("rst_bubble", 32'h0); push("rst_taken", 32'h0);
    chk(id_instr); chk(id_pc); chk({16'h0, stall_cnt});
    chk({30'h0, branch_sel}); chk({30'h0, j_sel}); chk({31'h0, stall});
    chk({31'h0, id_bubble}); chk({31'h0, taken});
    @(negedge clk);
    rst = 1'b0;

    // BEQ $1,$2, equal then unequal operands
    if_instr = BEQ12; if_pc = 32'h100; rf_rs_data = 32'd5; rf_rt_data = 32'd5;
    step();
    if_instr = FILL; if_pc = 32'h104;
    #1;
    push("beq_branch_sel", 32'h1); push("beq_taken", 32'h1); push("beq_stall", 32'h0);
    push("beq_i_imme", 32'h10); push("beq_rs_addr", 32'h1); push("beq_rt_addr", 32'h2);
    push("beq_id_pc", 32'h100);
    chk({30'h0, branch_sel}); chk({31'h0, taken}); chk({31'h0, stall});
    chk({16'h0, i_imme}); chk({27'h0, rs_addr}); chk({27'h0, rt_addr}); chk(id_pc);
    rf_rt_data = 32'd6;
    #1;
    push("beq_ne_taken", 32'h0);
    chk({31'h0, taken});

    // Load-use on BEQ $3,$0
    if_instr = BEQ30; if_pc = 32'h108;
    step();
    ex_wr_en = 1'b1; ex_is_load = 1'b1; ex_wr_reg = 5'd3;
    rf_rs_data = 32'd7; rf_rt_data = 32'd0; if_instr = FILL; if_pc = 32'h10c;
    #1;
    push("lu1_stall", 32'h1); push("lu1_bubble", 32'h1);
    push("lu1_branch_sel", 32'h0); push("lu1_taken", 32'h0);
    chk({31'h0, stall}); chk({31'h0, id_bubble}); chk({30'h0, branch_sel}); chk({31'h0, taken});
    step();
    ex_wr_en = 1'b0; ex_is_load = 1'b0; ex_wr_reg = 5'd0;
    mem_wr_en = 1'b1; mem_is_load = 1'b1; mem_wr_reg = 5'd3;
    #1;
    push("lu2_stall", 32'h1); push("lu2_id_instr", BEQ30);
    push("lu2_stall_cnt", 32'h1); push("lu2_bubble", 32'h1);
    chk({31'h0, stall}); chk(id_instr); chk({16'h0, stall_cnt}); chk({31'h0, id_bubble});
    step();
    mem_wr_en = 1'b0; mem_is_load = 1'b0; mem_wr_reg = 5'd0; rf_rs_data = 32'd0;
    #1;
    push("lu3_stall", 32'h0); push("lu3_taken", 32'h1); push("lu3_branch_sel", 32'h1);
    push("lu3_stall_cnt", 32'h2); push("lu3_id_instr", BEQ30);
    chk({31'h0, stall}); chk({31'h0, taken}); chk({30'h0, branch_sel});
    chk({16'h0, stall_cnt}); chk(id_instr);

    // J and delay slot
    rf_rs_data = 32'd1;
    if_instr = JMP; if_pc = 32'h200;
    step();
    if_instr = DS; if_pc = 32'h204;
    #1;
    push("j_j_sel", 32'h1); push("j_taken", 32'h1); push("j_j_imme", 32'h40); push("j_stall", 32'h0);
    chk({30'h0, j_sel}); chk({31'h0, taken}); chk({6'h0, j_imme}); chk({31'h0, stall});
    step();
`ifdef FLUSH_DELAY_SLOT_EN
    push("ds_id_instr", 32'h0);
`else
    push("ds_id_instr", DS);
`endif
    push("ds_id_pc", 32'h204);
    chk(id_instr); chk(id_pc);

    // JR $4 with MEM forward, then EX hazard on the same register
    if_instr = JR4; if_pc = 32'h300;
    step();
    if_instr = FILL; if_pc = 32'h304;
    mem_wr_en = 1'b1; mem_is_load = 1'b0; mem_wr_reg = 5'd4; mem_result = 32'h0040_0020;
    rf_rs_data = 32'd0; rf_rt_data = 32'd0;
    #1;
    push("jr_rs_data", 32'h0040_0020); push("jr_rt_data", 32'h0);
    push("jr_j_sel", 32'h2); push("jr_stall", 32'h0); push("jr_taken", 32'h1);
    chk(rs_data); chk(rt_data); chk({30'h0, j_sel}); chk({31'h0, stall}); chk({31'h0, taken});
    ex_wr_en = 1'b1; ex_wr_reg = 5'd4;
    #1;
    push("jr_haz_stall", 32'h1); push("jr_haz_j_sel", 32'h0);
    push("jr_haz_taken", 32'h0); push("jr_haz_bubble", 32'h1);
    chk({31'h0, stall}); chk({30'h0, j_sel}); chk({31'h0, taken}); chk({31'h0, id_bubble});
    ex_wr_en = 1'b0; ex_wr_reg = 5'd0; mem_wr_en = 1'b0; mem_wr_reg = 5'd0;

    // BNE $0,$5: $0 immunity, then real hazard on rt
    step();
    if_instr = BNE05; if_pc = 32'h400;
    step();
    ex_wr_en = 1'b1; ex_wr_reg = 5'd0; rf_rs_data = 32'd0; rf_rt_data = 32'd9;
    #1;
    push("z_stall", 32'h0); push("z_branch_sel", 32'h2); push("z_taken", 32'h1);
    chk({31'h0, stall}); chk({30'h0, branch_sel}); chk({31'h0, taken});
    ex_wr_reg = 5'd5;
    #1;
    push("rt_haz_stall", 32'h1); push("rt_haz_taken", 32'h0);
    chk({31'h0, stall}); chk({31'h0, taken});
    step();
    push("rt_haz_cnt", 32'h3); push("rt_haz_id_instr", BNE05); push("rt_haz_still", 32'h1);
    chk({16'h0, stall_cnt}); chk(id_instr); chk({31'h0, stall});

    // Asynchronous reset mid-stall, no clock edge
    #2;
    rst = 1'b1;
    #1;
    push("arst_id_instr", 32'h0); push("arst_id_pc", 32'h0); push("arst_stall", 32'h0);
    push("arst_stall_cnt", 32'h0); push("arst_bubble", 32'h0);
    chk(id_instr); chk(id_pc); chk({31'h0, stall}); chk({16'h0, stall_cnt}); chk({31'h0, id_bubble});
    @(negedge clk);
    rst = 1'b0;
    ex_wr_en = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/id_ctrl_flow.md
# id_ctrl_flow

ID-stage control-flow unit of the 5-stage pipeline, and the consumer of the fetch stage's outputs. It holds the IF/ID pipeline register and decodes BEQ, BNE, J, JR and JAL. It returns `branch_sel`, `j_sel`, the immediates and forwarded comparison operands to IF in the same cycle. It also detects operand hazards on control-flow instructions and stalls IF until the operands are valid.

## Interface
Parameters:
- `STALL_CNT_W`, default 16: width of the saturating stall counter.

Ports:
- `clk`  in  1  — single clock.
- `rst`  in  1  — asynchronous, active-high reset.
- `if_instr`  in  32  — fetched instruction from IF.
- `if_pc`  in  32  — PC of `if_instr`.
- `rf_rs_data`, `rf_rt_data`  in  32 each  — register-file read data.
- `ex_wr_en`, `ex_is_load`  in  1 each  — EX-stage instruction writes a register / is a load.
- `ex_wr_reg`  in  5  — EX destination register.
- `mem_wr_en`, `mem_is_load`  in  1 each  — MEM-stage equivalents.
- `mem_wr_reg`  in  5  — MEM destination register.
- `mem_result`  in  32  — MEM-stage ALU result.
- `id_instr`, `id_pc`  out  32 each  — registered IF/ID contents.
- `rs_addr`, `rt_addr`  out  5 each  — `id_instr[25:21]`, `id_instr[20:16]`.
- `branch_sel`  out  2  — 00 NOP, 01 BEQ, 10 BNE.
- `j_sel`  out  2  — 00 NOP, 01 J, 10 JR, 11 JAL.
- `i_imme`  out  16  — `id_instr[15:0]`.
- `j_imme`  out  26  — `id_instr[25:0]`.
- `rs_data`, `rt_data`  out  32 each  — forwarded operands for compare and JR.
- `stall`  out  1  — drives IF `en`; 1 holds the PC.
- `id_bubble`  out  1  — instructs ID/EX to insert a NOP.
- `taken`  out  1  — control transfer is taken this cycle.
- `stall_cnt`  out  `STALL_CNT_W`  — stall-cycle counter, saturating.

## Operation
- **Decode** of `id_instr[31:26]`:
  - 000100 → BEQ.
  - 000101 → BNE.
  - 000010 → J.
  - 000011 → JAL.
  - 000000 with funct 001000 → JR.
  - Anything else → both selects NOP.
- **Forwarding**, applied independently per operand with register number r:
  - If `mem_wr_en`, `!mem_is_load`, `mem_wr_reg == r` and r ≠ 0, use `mem_result`.
  - Otherwise use the `rf_*` data.
- **Hazard**: for BEQ/BNE (rs, rt) and JR (rs), for each used r ≠ 0, stall if either holds:
  - `ex_wr_en && ex_wr_reg == r`
  - `mem_wr_en && mem_is_load && mem_wr_reg == r`

  Non-control instructions never stall.
- **Stall effects**: while `stall = 1`, `branch_sel`, `j_sel` and `taken` are forced to NOP/0, `id_bubble = 1`, and IF/ID holds its contents.
- **Stall lengths**: a load in EX yields 2 stall cycles and an ALU result in EX yields 1, because the hazard is re-evaluated each cycle as the producer advances.
- **`taken`** = (BEQ and operands equal) or (BNE and operands unequal) or any jump, gated by `!stall`.
- **`stall_cnt`** increments on every cycle with `stall = 1` and saturates at all-ones.

## Timing
- **Reset**: `id_instr = 0`, `id_pc = 0`, `stall_cnt = 0`. As a result, `branch_sel = 00`, `j_sel = 00`, `stall = 0`, `id_bubble = 0` and `taken = 0` immediately.
- **IF/ID register**, on posedge `clk`:
  - If `stall`, hold.
  - Otherwise, load `if_instr` / `if_pc`.
- **Combinational outputs**: decode, forwarding, hazard, `stall`, `taken` and the immediates are combinational from the register and inputs, with zero-cycle latency to IF.
- **Branch latency**: the target takes effect at the next posedge; the instruction already in IF at that edge is the delay slot.
- **Reset mid-stall**: reset clears the register and the counter asynchronously; `stall` deasserts in the same cycle.
- **Simultaneous MEM forward and EX hazard on the same r**: stall wins, and the forward is irrelevant.

## Configuration
- `FLUSH_DELAY_SLOT_EN` defined: on a posedge where `taken = 1`, IF/ID loads `0` (NOP) instead of `if_instr` and keeps `if_pc`, so the delay slot is squashed.
- `FLUSH_DELAY_SLOT_EN` undefined: the delay slot always executes (MIPS semantics).

## Test plan
- **BEQ, no hazard**: BEQ $1,$2 with rf = 5/5 → `branch_sel = 01`, `taken = 1`, `stall = 0`. With rf = 5/6 → `taken = 0`.
- **Load-use**: BEQ $3,$0 with a load to $3 in EX → `stall = 1` for exactly 2 cycles, `id_bubble = 1`, `id_instr` held. Then `taken` resolves, and `stall_cnt = 2`.
- **MEM forward**: JR $4, `mem_wr_reg = 4`, `mem_result = 0x00400020`, rf = 0 → `rs_data = 0x00400020`, `j_sel = 10`, no stall.
- **$0 immunity**: BNE $0,$5 with `ex_wr_reg = 0` and `ex_wr_en = 1` → no stall.
- **Delay-slot flush**: J with the macro defined → next `id_instr = 0`. With it undefined → next `id_instr` = the fetched delay slot.
- **Async reset**: assert `rst` mid-stall with no clock edge → `id_instr = 0`, `stall = 0`, `stall_cnt = 0` immediately.
